// File: rtl/otter_intr_ctrl_if.sv
// Interrupt sequencer bundle: pipeline/CSR inputs and redirect/trap outputs.
// Combinational wiring only; STALL stands in for backpressure. INT_COUNT/DROPPED exist only with INTR_COUNT_EN.
interface otter_intr_ctrl_if #(
    parameter int PC_WIDTH = 32
);
    logic                INTR;
    logic                CSR_MIE;
    logic [PC_WIDTH-1:0] CSR_MTVEC;
    logic [PC_WIDTH-1:0] CSR_MEPC;
    logic                EX_VALID;
    logic [PC_WIDTH-1:0] EX_PC;
    logic                EX_IS_MRET;
    logic                STALL;
    logic                INT_TAKEN;
    logic [PC_WIDTH-1:0] INT_PC;
    logic                FLUSH;
    logic                REDIRECT;
    logic [PC_WIDTH-1:0] REDIRECT_ADDR;
    logic                IN_HANDLER;
    logic                PENDING;
`ifdef INTR_COUNT_EN
    logic [31:0]         INT_COUNT;
    logic                DROPPED;
`endif

    modport slave (
        input  INTR, CSR_MIE, CSR_MTVEC, CSR_MEPC, EX_VALID, EX_PC, EX_IS_MRET, STALL,
        output INT_TAKEN, INT_PC, FLUSH, REDIRECT, REDIRECT_ADDR, IN_HANDLER, PENDING
`ifdef INTR_COUNT_EN
        , output INT_COUNT, DROPPED
`endif
    );

    modport master (
        output INTR, CSR_MIE, CSR_MTVEC, CSR_MEPC, EX_VALID, EX_PC, EX_IS_MRET, STALL,
        input  INT_TAKEN, INT_PC, FLUSH, REDIRECT, REDIRECT_ADDR, IN_HANDLER, PENDING
`ifdef INTR_COUNT_EN
        , input INT_COUNT, DROPPED
`endif
    );
endinterface

// File: rtl/otter_intr_ctrl.sv
// Interrupt/trap sequencer: synchronises INTR, takes it at an EX boundary, redirects to MTVEC/MEPC.
// Latency: INTR high at edge k -> PENDING after k+2 (SYNC_STAGES=2); outputs are Moore, one cycle after the decision.
// Backpressure: STALL or a bubble in EX holds the sequencer in IDLE/HANDLER. Optional INTR_COUNT_EN adds INT_COUNT/DROPPED.
module otter_intr_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int PC_WIDTH    = 32
) (
    input  logic               CLK,
    input  logic               RST,
    otter_intr_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TAKE    = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   pending_q, pending_d;
    logic [PC_WIDTH-1:0]    int_pc_q, int_pc_d;
    logic [PC_WIDTH-1:0]    raddr_q, raddr_d;
    logic                   sync_out;
    logic                   edge_det;
    logic                   mret_go;

    // sync_q[0] samples the pin; the top bit is the synchronised output.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], bus.INTR};
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign hist_d   = sync_out;
    assign edge_det = sync_out & ~hist_q;
    assign mret_go  = bus.EX_VALID & bus.EX_IS_MRET & ~bus.STALL;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        int_pc_d  = int_pc_q;
        raddr_d   = raddr_q;
        case (state_q)
            ST_IDLE: begin
                // MRET wins; the else-branch therefore implies !EX_IS_MRET.
                if (mret_go) begin
                    state_d = ST_RETURN;
                    raddr_d = bus.CSR_MEPC;
                end else if (pending_q && bus.CSR_MIE && bus.EX_VALID && !bus.STALL) begin
                    state_d   = ST_TAKE;
                    int_pc_d  = bus.EX_PC;
                    raddr_d   = bus.CSR_MTVEC;
                    pending_d = 1'b0;
                end
            end
            ST_TAKE:    state_d = ST_HANDLER;
            ST_HANDLER: begin
                if (mret_go) begin
                    state_d = ST_RETURN;
                    raddr_d = bus.CSR_MEPC;
                end
            end
            ST_RETURN:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        // A fresh edge overrides the clear so a request arriving mid-take is not lost.
        if (edge_det) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            sync_q    <= '0;
            hist_q    <= 1'b0;
            pending_q <= 1'b0;
            int_pc_q  <= '0;
            raddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            pending_q <= pending_d;
            int_pc_q  <= int_pc_d;
            raddr_q   <= raddr_d;
        end
    end

    assign bus.INT_TAKEN     = (state_q == ST_TAKE);
    assign bus.FLUSH         = (state_q == ST_TAKE) || (state_q == ST_RETURN);
    assign bus.REDIRECT      = (state_q == ST_TAKE) || (state_q == ST_RETURN);
    assign bus.IN_HANDLER    = (state_q == ST_HANDLER);
    assign bus.PENDING       = pending_q;
    assign bus.INT_PC        = int_pc_q;
    assign bus.REDIRECT_ADDR = raddr_q;

`ifdef INTR_COUNT_EN
    logic [31:0] count_q, count_d;
    logic        dropped_q, dropped_d;

    always_comb begin
        count_d   = count_q;
        dropped_d = dropped_q;
        if (state_q == ST_TAKE) begin
            count_d = count_q + 32'd1;
        end
        // A second edge while one is already waiting gets coalesced into it.
        if (edge_det && pending_q) begin
            dropped_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q   <= '0;
            dropped_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.INT_COUNT = count_q;
    assign bus.DROPPED   = dropped_q;
`endif

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Self-checking bench for otter_intr_ctrl: directed scenarios plus a randomized run against a flag-level model.
module tb_otter_intr_ctrl;
    localparam int S  = 2;
    localparam int PW = 32;
`ifdef INTR_COUNT_EN
    localparam int OW = 5 + 2*PW + 33;
`else
    localparam int OW = 5 + 2*PW;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    otter_intr_ctrl_if #(.PC_WIDTH(PW)) bus ();
    otter_intr_ctrl #(.SYNC_STAGES(S), .PC_WIDTH(PW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    // Reference model: pin-sample history plus "what happened last cycle" flags.
    bit          hs[$];
    bit          m_taken, m_ret, m_handler, m_pending, m_dropped;
    logic [31:0] m_int_pc, m_raddr, m_count;

    function automatic logic [OW-1:0] mdl_obs();
`ifdef INTR_COUNT_EN
        return {m_taken, m_taken | m_ret, m_taken | m_ret, m_handler, m_pending, m_int_pc, m_raddr, m_count, m_dropped};
`else
        return {m_taken, m_taken | m_ret, m_taken | m_ret, m_handler, m_pending, m_int_pc, m_raddr};
`endif
    endfunction

    function automatic logic [OW-1:0] dut_obs();
`ifdef INTR_COUNT_EN
        return {bus.INT_TAKEN, bus.FLUSH, bus.REDIRECT, bus.IN_HANDLER, bus.PENDING, bus.INT_PC, bus.REDIRECT_ADDR, bus.INT_COUNT, bus.DROPPED};
`else
        return {bus.INT_TAKEN, bus.FLUSH, bus.REDIRECT, bus.IN_HANDLER, bus.PENDING, bus.INT_PC, bus.REDIRECT_ADDR};
`endif
    endfunction

    task automatic mdl_reset();
        hs.delete();
        for (int i = 0; i <= S; i++) hs.push_back(1'b0);
        m_taken = 0; m_ret = 0; m_handler = 0; m_pending = 0; m_dropped = 0;
        m_int_pc = '0; m_raddr = '0; m_count = '0;
    endtask

    // One clock edge: the model consumes the same inputs the DUT sampled, then outputs settle.
    task automatic step();
        bit e, tk, rt;
        @(posedge CLK);
        if (RST) begin
            mdl_reset();
        end else begin
            e  = hs[hs.size()-S] && !hs[hs.size()-S-1];
            tk = !m_taken && !m_ret && !m_handler && m_pending && bus.CSR_MIE
                 && bus.EX_VALID && !bus.STALL && !bus.EX_IS_MRET;
            rt = !m_taken && !m_ret && bus.EX_VALID && bus.EX_IS_MRET && !bus.STALL;
            if (m_taken) m_count = m_count + 1;
            if (e && m_pending) m_dropped = 1;
            m_handler = m_taken || (m_handler && !rt);
            m_pending = e || (m_pending && !tk);
            if (tk) begin m_int_pc = bus.EX_PC; m_raddr = bus.CSR_MTVEC; end
            if (rt) m_raddr = bus.CSR_MEPC;
            m_taken = tk;
            m_ret   = rt;
            hs.push_back(bus.INTR);
            if (hs.size() > S + 2) void'(hs.pop_front());
        end
        #1;
    endtask

    task automatic set_idle_inputs();
        bus.INTR = 0; bus.CSR_MIE = 0; bus.CSR_MTVEC = '0; bus.CSR_MEPC = '0;
        bus.EX_VALID = 0; bus.EX_PC = '0; bus.EX_IS_MRET = 0; bus.STALL = 0;
    endtask

    task automatic do_reset();
        set_idle_inputs();
        RST = 1; step(); step(); RST = 0;
    endtask

    task automatic test_reset();
        set_idle_inputs();
        RST = 1;
        for (int c = 0; c < 2; c++) begin
            bus.INTR = ~bus.INTR;
            step();
            checks++;
            if (dut_obs() !== '0) begin
                errors++; $display("FAIL reset_outputs cyc=%0d got=%h exp=0", c, dut_obs());
            end
        end
        RST = 0; bus.INTR = 0;
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (bus.PENDING !== 1'b0 || dut_obs() !== mdl_obs()) begin
            errors++; $display("FAIL reset_release got=%h exp=%h", dut_obs(), mdl_obs());
        end
    endtask

    task automatic test_take();
        do_reset();
        bus.CSR_MIE = 1; bus.EX_VALID = 1; bus.EX_PC = 32'h100; bus.CSR_MTVEC = 32'h400; bus.INTR = 1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (dut_obs() !== mdl_obs()) begin
                errors++; $display("FAIL take_model cyc=%0d got=%h exp=%h", c, dut_obs(), mdl_obs());
            end
            checks++;
            case (c)
                1: if (bus.PENDING !== 1'b0) begin
                       errors++; $display("FAIL take_pend_early got=%b exp=0", bus.PENDING);
                   end
                2: if ({bus.PENDING, bus.INT_TAKEN} !== 2'b10) begin
                       errors++; $display("FAIL take_pend_k2 got=%b exp=10", {bus.PENDING, bus.INT_TAKEN});
                   end
                3: if ({bus.INT_TAKEN, bus.FLUSH, bus.REDIRECT, bus.INT_PC, bus.REDIRECT_ADDR} !== {3'b111, 32'h100, 32'h400}) begin
                       errors++; $display("FAIL take_pulse got=%b/%h/%h exp=111/100/400",
                                          {bus.INT_TAKEN, bus.FLUSH, bus.REDIRECT}, bus.INT_PC, bus.REDIRECT_ADDR);
                   end
                4: if ({bus.INT_TAKEN, bus.FLUSH, bus.IN_HANDLER} !== 3'b001) begin
                       errors++; $display("FAIL take_handler got=%b exp=001", {bus.INT_TAKEN, bus.FLUSH, bus.IN_HANDLER});
                   end
                default: if (bus.INT_TAKEN !== 1'b0) begin
                       errors++; $display("FAIL take_quiet cyc=%0d got=%b exp=0", c, bus.INT_TAKEN);
                   end
            endcase
        end
        bus.INTR = 0;
    endtask

    // Continues from HANDLER left by test_take.
    task automatic test_handler_mret();
        int seen = 0;
        for (int c = 0; c < 7; c++) begin
            if (c == 3) bus.INTR = 1;
            step();
            seen += int'(bus.INT_TAKEN);
            checks++;
            if (dut_obs() !== mdl_obs()) begin
                errors++; $display("FAIL hnd_model cyc=%0d got=%h exp=%h", c, dut_obs(), mdl_obs());
            end
        end
        checks++;
        if ({bus.PENDING, bus.IN_HANDLER} !== 2'b11 || seen != 0) begin
            errors++; $display("FAIL hnd_masked got pend/hnd=%b taken=%0d exp=11 taken=0", {bus.PENDING, bus.IN_HANDLER}, seen);
        end
        bus.CSR_MEPC = 32'h100; bus.EX_IS_MRET = 1;
        step();
        bus.EX_IS_MRET = 0;
        checks++;
        if ({bus.FLUSH, bus.REDIRECT, bus.INT_TAKEN, bus.IN_HANDLER, bus.REDIRECT_ADDR} !== {4'b1100, 32'h100}) begin
            errors++; $display("FAIL mret_redirect got=%b/%h exp=1100/100",
                               {bus.FLUSH, bus.REDIRECT, bus.INT_TAKEN, bus.IN_HANDLER}, bus.REDIRECT_ADDR);
        end
        step();
        checks++;
        if ({bus.INT_TAKEN, bus.FLUSH, bus.IN_HANDLER, bus.PENDING} !== 4'b0001) begin
            errors++; $display("FAIL mret_idle got=%b exp=0001", {bus.INT_TAKEN, bus.FLUSH, bus.IN_HANDLER, bus.PENDING});
        end
        step();
        checks++;
        if ({bus.INT_TAKEN, bus.REDIRECT_ADDR} !== {1'b1, 32'h400} || dut_obs() !== mdl_obs()) begin
            errors++; $display("FAIL mret_retake got=%b/%h exp=1/400", bus.INT_TAKEN, bus.REDIRECT_ADDR);
        end
        bus.INTR = 0;
    endtask

    task automatic test_mie_off();
        int seen = 0;
        do_reset();
        bus.EX_VALID = 1; bus.EX_PC = 32'h2000; bus.CSR_MTVEC = 32'h800; bus.INTR = 1;
        for (int c = 0; c < 24; c++) begin
            if (c == 2) bus.INTR = 0;
            step();
            seen += int'(bus.INT_TAKEN);
            checks++;
            if (dut_obs() !== mdl_obs()) begin
                errors++; $display("FAIL mie_model cyc=%0d got=%h exp=%h", c, dut_obs(), mdl_obs());
            end
        end
        checks++;
        if (bus.PENDING !== 1'b1 || seen != 0) begin
            errors++; $display("FAIL mie_hold got pend=%b taken=%0d exp pend=1 taken=0", bus.PENDING, seen);
        end
        bus.CSR_MIE = 1;
        step();
        checks++;
        if ({bus.INT_TAKEN, bus.INT_PC} !== {1'b1, 32'h2000}) begin
            errors++; $display("FAIL mie_enable got=%b/%h exp=1/2000", bus.INT_TAKEN, bus.INT_PC);
        end
    endtask

    task automatic test_stall();
        int          seen = 0;
        logic [31:0] pc;
        do_reset();
        bus.CSR_MIE = 1; bus.EX_VALID = 1; bus.STALL = 1; bus.CSR_MTVEC = 32'hC00; bus.INTR = 1;
        for (int c = 0; c < 8; c++) begin
            bus.EX_PC = $urandom;
            step();
            seen += int'(bus.INT_TAKEN);
            checks++;
            if (dut_obs() !== mdl_obs()) begin
                errors++; $display("FAIL stall_model cyc=%0d got=%h exp=%h", c, dut_obs(), mdl_obs());
            end
        end
        checks++;
        if (bus.PENDING !== 1'b1 || seen != 0) begin
            errors++; $display("FAIL stall_hold got pend=%b taken=%0d exp pend=1 taken=0", bus.PENDING, seen);
        end
        pc = $urandom;
        bus.STALL = 0; bus.EX_PC = pc;
        step();
        checks++;
        if ({bus.INT_TAKEN, bus.INT_PC} !== {1'b1, pc}) begin
            errors++; $display("FAIL stall_release got=%b/%h exp=1/%h", bus.INT_TAKEN, bus.INT_PC, pc);
        end
    endtask

    task automatic test_reset_mid_take();
        do_reset();
        bus.CSR_MIE = 1; bus.EX_VALID = 1; bus.EX_PC = 32'h40; bus.CSR_MTVEC = 32'h80; bus.INTR = 1;
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (bus.INT_TAKEN !== 1'b1) begin
            errors++; $display("FAIL rst_take_setup got=%b exp=1", bus.INT_TAKEN);
        end
        RST = 1; bus.INTR = 0;
        step();
        checks++;
        if ({bus.INT_TAKEN, bus.IN_HANDLER, bus.PENDING, bus.FLUSH} !== 4'b0000) begin
            errors++; $display("FAIL rst_take got=%b exp=0000", {bus.INT_TAKEN, bus.IN_HANDLER, bus.PENDING, bus.FLUSH});
        end
        RST = 0;
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (dut_obs() !== mdl_obs() || bus.PENDING !== 1'b0) begin
            errors++; $display("FAIL rst_take_after got=%h exp=%h", dut_obs(), mdl_obs());
        end
    endtask

`ifdef INTR_COUNT_EN
    task automatic test_count();
        do_reset();
        bus.CSR_MIE = 1; bus.EX_VALID = 1; bus.EX_PC = 32'h10; bus.CSR_MTVEC = 32'h20; bus.CSR_MEPC = 32'h10;
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 10; c++) begin
                bus.INTR       = (c < 2);
                bus.EX_IS_MRET = (c == 7);
                step();
            end
        end
        checks++;
        if ({bus.INT_COUNT, bus.DROPPED} !== {32'd3, 1'b0}) begin
            errors++; $display("FAIL count_three got=%0d/%b exp=3/0", bus.INT_COUNT, bus.DROPPED);
        end
        bus.CSR_MIE = 0;
        for (int c = 0; c < 12; c++) begin
            bus.INTR = (c < 2) || (c >= 4 && c < 6);
            step();
        end
        checks++;
        if ({bus.DROPPED, bus.PENDING} !== 2'b11 || dut_obs() !== mdl_obs()) begin
            errors++; $display("FAIL count_dropped got=%b exp=11", {bus.DROPPED, bus.PENDING});
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(5, 0) == 0) bus.INTR = ~bus.INTR;
            bus.CSR_MIE    = ($urandom_range(7, 0) != 0);
            bus.EX_VALID   = ($urandom_range(3, 0) != 0);
            bus.STALL      = ($urandom_range(3, 0) == 0);
            bus.EX_IS_MRET = ($urandom_range(9, 0) == 0);
            bus.EX_PC      = $urandom;
            bus.CSR_MTVEC  = $urandom;
            bus.CSR_MEPC   = $urandom;
            RST            = ($urandom_range(199, 0) == 0);
            step();
            checks++;
            if (dut_obs() !== mdl_obs()) begin
                errors++; $display("FAIL random_model cyc=%0d got=%h exp=%h", c, dut_obs(), mdl_obs());
            end
        end
        RST = 0;
    endtask

    initial begin
        set_idle_inputs();
        mdl_reset();
        test_reset();
        test_take();
        test_handler_mret();
        test_mie_off();
        test_stall();
        test_reset_mid_take();
`ifdef INTR_COUNT_EN
        test_count();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
